// File: rtl/cen_frac_gen.sv
// cen_frac_gen: runtime-programmable fractional clock-enable generator.
// Each channel emits `cen` at an average rate of num/den of clk_sys, plus a
// half-rate companion `cen_half` that fires on every other `cen` pulse.
// New ratios are written into a shadow and swapped in at a pulse boundary, so
// a running channel never produces a short or stretched period.
// Optional feature macro: CEN_FRAC_STATS_EN adds per-channel saturating pulse
// counters readable through stat_ch/stat_cnt. Without it, stat_cnt reads 0.
module cen_frac_gen #(
    parameter int CHANNELS = 3,
    parameter int ACC_W    = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                run,
    input  logic                sync,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [ACC_W-1:0]    cfg_num,
    input  logic [ACC_W-1:0]    cfg_den,
    output logic                cfg_ack,
    output logic [CHANNELS-1:0] cen,
    output logic [CHANNELS-1:0] cen_half,
    input  logic [CH_W-1:0]     stat_ch,
    output logic [15:0]         stat_cnt
);

    logic ack_reg;

    // Acknowledge every write that targets an existing channel.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ack_reg <= 1'b0;
        end else begin
            ack_reg <= cfg_wr && (32'(cfg_ch) < CHANNELS);
        end
    end

    assign cfg_ack = ack_reg;

`ifdef CEN_FRAC_STATS_EN
    logic [15:0] stat_arr [CHANNELS];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [ACC_W-1:0] acc_reg, acc_next;
            logic [ACC_W-1:0] num_reg, num_next;
            logic [ACC_W-1:0] den_reg, den_next;
            logic [ACC_W-1:0] sh_num_reg, sh_num_next;
            logic [ACC_W-1:0] sh_den_reg, sh_den_next;
            logic             pend_reg, pend_next;
            logic             ht_reg, ht_next;
            logic             cen_reg, cen_next;
            logic             half_reg, half_next;
            logic [ACC_W-1:0] eff_den;
            logic [ACC_W:0]   sum;
            logic             idle;
            logic             fire;
            logic             wr_hit;

            assign wr_hit  = cfg_wr && (cfg_ch == CH_W'(gi));
            assign idle    = (num_reg == '0);
            // A zero denominator behaves as den = num, i.e. a pulse every cycle.
            assign eff_den = (den_reg == '0) ? num_reg : den_reg;
            // acc < den and num < den in the normal path, so this never overflows.
            assign sum     = {1'b0, acc_reg} + {1'b0, num_reg};

            // Accumulator step, pulse generation and shadow/apply handling.
            always_comb begin
                acc_next    = acc_reg;
                num_next    = num_reg;
                den_next    = den_reg;
                sh_num_next = sh_num_reg;
                sh_den_next = sh_den_reg;
                pend_next   = pend_reg;
                ht_next     = ht_reg;
                cen_next    = 1'b0;
                half_next   = 1'b0;
                fire        = 1'b0;

                if (sync) begin
                    // Realign: restart phase, force any pending ratio in now.
                    // A write on this same edge takes effect immediately too.
                    acc_next  = '0;
                    ht_next   = 1'b0;
                    pend_next = 1'b0;
                    if (wr_hit) begin
                        sh_num_next = cfg_num;
                        sh_den_next = cfg_den;
                        num_next    = cfg_num;
                        den_next    = cfg_den;
                    end else if (pend_reg) begin
                        num_next = sh_num_reg;
                        den_next = sh_den_reg;
                    end
                end else begin
                    if (run && !idle) begin
                        if (num_reg >= eff_den) begin
                            // Ratio of one or more saturates to every cycle.
                            fire     = 1'b1;
                            acc_next = '0;
                        end else if (sum >= {1'b0, eff_den}) begin
                            fire     = 1'b1;
                            acc_next = ACC_W'(sum - {1'b0, eff_den});
                        end else begin
                            acc_next = sum[ACC_W-1:0];
                        end
                    end

                    cen_next  = fire;
                    half_next = fire && !ht_reg;
                    if (fire) begin
                        ht_next = !ht_reg;
                    end

                    // Swap ratios only at a pulse boundary, or whenever the
                    // channel is not producing pulses anyway.
                    if (pend_reg && (fire || idle || !run)) begin
                        num_next  = sh_num_reg;
                        den_next  = sh_den_reg;
                        acc_next  = '0;
                        pend_next = 1'b0;
                    end

                    // Latest write wins; it re-arms pending even on an apply edge.
                    if (wr_hit) begin
                        sh_num_next = cfg_num;
                        sh_den_next = cfg_den;
                        pend_next   = 1'b1;
                    end
                end
            end

            // Channel state registers; reset leaves the channel idle.
            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    acc_reg    <= '0;
                    num_reg    <= '0;
                    den_reg    <= ACC_W'(1);
                    sh_num_reg <= '0;
                    sh_den_reg <= ACC_W'(1);
                    pend_reg   <= 1'b0;
                    ht_reg     <= 1'b0;
                    cen_reg    <= 1'b0;
                    half_reg   <= 1'b0;
                end else begin
                    acc_reg    <= acc_next;
                    num_reg    <= num_next;
                    den_reg    <= den_next;
                    sh_num_reg <= sh_num_next;
                    sh_den_reg <= sh_den_next;
                    pend_reg   <= pend_next;
                    ht_reg     <= ht_next;
                    cen_reg    <= cen_next;
                    half_reg   <= half_next;
                end
            end

            assign cen[gi]      = cen_reg;
            assign cen_half[gi] = half_reg;

`ifdef CEN_FRAC_STATS_EN
            logic [15:0] cnt_reg, cnt_next;

            // Saturating pulse counter, cleared by sync.
            always_comb begin
                cnt_next = cnt_reg;
                if (sync) begin
                    cnt_next = '0;
                end else if (cen_next && (cnt_reg != 16'hFFFF)) begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            // Counter register.
            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign stat_arr[gi] = cnt_reg;
`endif
        end
    endgenerate

`ifdef CEN_FRAC_STATS_EN
    logic [15:0] stat_reg;

    // Registered readout of the selected channel's counter.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            stat_reg <= '0;
        end else if (32'(stat_ch) < CHANNELS) begin
            stat_reg <= stat_arr[stat_ch];
        end else begin
            stat_reg <= '0;
        end
    end

    assign stat_cnt = stat_reg;
`else
    logic unused_stat_ch;
    assign unused_stat_ch = ^stat_ch;
    assign stat_cnt       = '0;
`endif

endmodule

// File: doc/cen_frac_gen.md
# cen_frac_gen

Parametrised, runtime-programmable fractional clock-enable generator; successor to the fixed-ratio `jtframe_cen24` divider.
- Produces `CHANNELS` independent pixel/CPU enables from `clk_sys`, each at an arbitrary `num/den` ratio.
- Also produces a half-rate companion enable per channel.
- Sits between the sim/FPGA top and `system`, replacing the hard-wired divider so one build can run several video/CPU timings.

## Interface
Parameters:
- `CHANNELS`, 3, number of independent enable channels (1..8)
- `ACC_W`, 16, width of numerator/denominator; accumulator is `ACC_W+1` bits

Ports:
- `clk_sys`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `run`  in  1  global enable; low freezes all accumulators
- `sync`  in  1  one-cycle pulse; realigns all channel phases
- `cfg_wr`  in  1  configuration write strobe
- `cfg_ch`  in  `$clog2(CHANNELS)` (min 1)  target channel
- `cfg_num`  in  `ACC_W`  ratio numerator
- `cfg_den`  in  `ACC_W`  ratio denominator
- `cfg_ack`  out  1  one-cycle acknowledge of an accepted write
- `cen`  out  `CHANNELS`  per-channel enable pulses
- `cen_half`  out  `CHANNELS`  every second `cen` pulse of the channel
- `stat_ch`  in  `$clog2(CHANNELS)`  statistics channel select
- `stat_cnt`  out  16  pulse count of selected channel

## Operation
- Per channel state: active `num`/`den`, shadow `num`/`den`, pending flag, accumulator `acc`, toggle `ht`.
- Each cycle with `run`=1 and active `num`≠0:
  - `s = acc + num`.
  - If `s >= den`: `acc <= s - den`, `cen <= 1`.
  - Otherwise: `acc <= s`, `cen <= 0`.
- Invariant: `acc < den`; `s < 2*den` fits `ACC_W+1` bits.
- Clamping:
  - `num >= den` → `cen` high every cycle while running.
  - `den == 0` is treated as `den = num` (every cycle).
  - `num == 0` → channel idle, `cen` held 0.
- `cen_half`:
  - Each `cen` pulse toggles `ht`.
  - `cen_half <= cen_next & ~ht`, so it fires on the 1st, 3rd, 5th… pulse after reset/sync.
- `run` = 0: `acc`, `ht` hold; `cen`, `cen_half` = 0 next cycle.
- Configuration:
  - `cfg_wr` loads the shadow registers of `cfg_ch` and sets pending.
  - `cfg_ack` pulses the following cycle.
  - `cfg_ch >= CHANNELS`: write ignored, no ack.
- Pending config is applied glitch-free at that channel's next wrap (the cycle `cen` is generated); `acc` restarts from 0.
- Pending config is applied immediately on the next edge if the channel is idle (`num`=0) or `run`=0.
- A second write before apply overwrites the shadow (last write wins); one ack per write.
- `sync`: all `acc` <= 0, `ht` <= 0, all pending configs applied, `cen`/`cen_half` <= 0 that cycle.
- `sync` and `cfg_wr` on the same edge: the write lands in shadow and is applied in the same cycle as the sync.

## Timing
- Reset (async, `reset_n`=0):
  - `acc`=0, `num`=0, `den`=1, pending=0, `ht`=0.
  - `cen`=0, `cen_half`=0, `cfg_ack`=0, `stat_cnt`=0.
  - All channels idle until configured.
- Outputs are registered: `cen` rises on the same edge that wraps `acc`.
- With `num`=1, `den`=N, first `cen` is high after the Nth running edge, then every N edges.
- Latency:
  - `cfg_wr` → `cfg_ack`: 1 cycle.
  - Apply to idle channel: 1 cycle.
  - Apply to active channel: ≤ `den` cycles.
- Reset deassertion mid-run restarts every channel idle; no partial pulse is emitted.

## Configuration
- `CEN_FRAC_STATS_EN` defined:
  - Per-channel 16-bit saturating counter of `cen` pulses (stops at 0xFFFF).
  - Cleared by reset and `sync`.
  - `stat_cnt` = counter[`stat_ch`], registered, 1 cycle latency.
- Not defined: counters are removed; `stat_cnt` is tied to 0.

## Test plan
- `num`=1, `den`=6 on ch0, `run`=1 → `cen[0]` high on edges 6, 12, 18…; `cen_half[0]` on 6, 18, 30.
- `num`=2, `den`=3 on ch1 → `cen[1]` pattern 0,1,1 repeating; exactly 200 pulses in 300 cycles.
- Ch0 at 1/4, write 1/2 at cycle 2 → `cfg_ack` at cycle 3; period stays 4 until the wrap at cycle 4, then becomes 2 (pulses at 4, 6, 8).
- `num`=5, `den`=3 and `den`=0 cases → `cen` high every running cycle; `num`=0 → `cen` stays 0.
- Toggle `run` low for 10 cycles mid-period, 1/4 → pulse schedule shifts by exactly 10; `cen` low throughout the pause.
- Assert `reset_n`=0 asynchronously mid-period → all outputs 0 immediately. With `CEN_FRAC_STATS_EN`: 1/1 for 70000 cycles → `stat_cnt`=0xFFFF; `sync` → 0.
